// File: rtl/dnn_argmax_fix.sv
// Argmax over the engine's score vector: snapshot on start, then one signed compare per cycle.
// Latency: done rises NUM_CLASSES-1 edges after the accepting edge; busy is high for NUM_CLASSES-1 cycles.
// Backpressure: none; start is ignored while scanning, and the result is held until the next accepted start.
module dnn_argmax_fix #(
    parameter int DATA_WIDTH  = 8,
    parameter int NUM_CLASSES = 10,
    parameter int IDX_WIDTH   = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start,
    input  logic signed [DATA_WIDTH-1:0] scores [NUM_CLASSES],
    output logic                         busy,
    output logic                         done,
    output logic        [IDX_WIDTH-1:0]  class_idx,
    output logic signed [DATA_WIDTH-1:0] max_val
);

    typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

    state_t                       state;
    logic signed [DATA_WIDTH-1:0] snap [NUM_CLASSES];
    logic signed [DATA_WIDTH-1:0] best_val;
    logic        [IDX_WIDTH-1:0]  best_idx;
    logic        [IDX_WIDTH-1:0]  ptr;

    logic signed [DATA_WIDTH-1:0] cand;
    logic                         take;
    logic signed [DATA_WIDTH-1:0] next_val;
    logic        [IDX_WIDTH-1:0]  next_idx;
    logic                         last;

    // Strict compare keeps the lowest index on ties.
    always_comb begin
        cand     = snap[ptr];
        take     = cand > best_val;
        next_val = take ? cand : best_val;
        next_idx = take ? ptr  : best_idx;
        last     = (ptr == IDX_WIDTH'(NUM_CLASSES - 1));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            busy      <= 1'b0;
            done      <= 1'b0;
            class_idx <= '0;
            max_val   <= '0;
            best_val  <= '0;
            best_idx  <= '0;
            ptr       <= '0;
            for (int i = 0; i < NUM_CLASSES; i++) snap[i] <= '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        for (int i = 0; i < NUM_CLASSES; i++) snap[i] <= scores[i];
                        best_val <= scores[0];
                        best_idx <= '0;
                        ptr      <= IDX_WIDTH'(1);
                        state    <= SCAN;
                        busy     <= 1'b1;
                        done     <= 1'b0;
                    end
                end
                SCAN: begin
                    best_val <= next_val;
                    best_idx <= next_idx;
                    if (last) begin
                        class_idx <= next_idx;
                        max_val   <= next_val;
                        state     <= DONE;
                        busy      <= 1'b0;
                        done      <= 1'b1;
                    end else begin
                        ptr <= ptr + 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/dnn_argmax_fix.md
Name: dnn_argmax_fix

Overview:
- Classification stage directly downstream of the fixed-point ReLU inference engine.
- Captures the engine's ten signed output scores when the engine signals completion.
- Scans the scores serially, one per cycle, and reports the index of the largest score as the predicted MNIST digit, together with that score.
- Serial compare is used to keep the comparator count at one and to decouple from the engine's output timing.

Parameters:
- DATA_WIDTH, 8, width of each signed score.
- NUM_CLASSES, 10, number of scores; must be at least 2.
- IDX_WIDTH, 4, width of the class index; must satisfy 2^IDX_WIDTH >= NUM_CLASSES.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous active-high reset.
- start  in  1  begin classification; driven from the engine's done.
- scores  in  signed [DATA_WIDTH-1:0] x NUM_CLASSES  engine output vector; sampled only on an accepted start.
- busy  out  1  high while a scan is in progress.
- done  out  1  high when a result is valid; held until the next accepted start or rst.
- class_idx  out  IDX_WIDTH  index of the maximum score.
- max_val  out  signed [DATA_WIDTH-1:0]  the maximum score.

Behaviour:
- Reset: when rst is sampled high at a rising edge:
  - state becomes IDLE;
  - busy, done, class_idx and max_val are all 0;
  - snapshot and internal registers are cleared.
  - rst mid-scan aborts the scan and leaves no partial result.
- States: IDLE, SCAN, DONE.
- IDLE or DONE, start=1 (accept):
  - copy all of scores into the snapshot register;
  - best_val <= snapshot[0], best_idx <= 0, ptr <= 1;
  - go to SCAN; busy=1, done=0 from the next cycle.
  - class_idx and max_val keep the previous result until the new result completes.
- SCAN, each cycle:
  - compare snapshot[ptr] > best_val, signed and strict;
  - if true, best_val and best_idx take snapshot[ptr] and ptr;
  - ptr increments.
  - When ptr == NUM_CLASSES-1, the compare is performed and, in the same cycle:
    - class_idx and max_val take the final best, including this compare;
    - state becomes DONE; busy=0, done=1 from the next cycle.
- Latency: done is visible NUM_CLASSES-1 rising edges after the edge that accepts start (9 for the defaults). busy is high for exactly NUM_CLASSES-1 cycles.
- start while in SCAN is ignored; the scan continues unaffected.
- Changes on scores after acceptance have no effect, because the scan uses the snapshot.
- Ties: the lowest index wins (strict greater-than).
- All-equal or all-negative vectors resolve by the same rule; for example, all -128 gives class_idx=0 and max_val=-128.
- start held high continuously: each entry to DONE is followed by a re-accept on the next edge. done pulses for one cycle per result and results repeat back-to-back.
- No arithmetic beyond the signed compare; no widening, no saturation.
- Inside the module, the ptr counter never exceeds NUM_CLASSES-1.

Test Plan:
- Distinct max, mid-vector: scores = {0,3,-5,10,2,1,7,20,-1,4} (idx0..9), 1-cycle start -> done after 9 edges; class_idx=7, max_val=20; busy high exactly 9 cycles.
- Boundary positions:
  - max only at idx 0 (scores[0]=127, others 0) -> class_idx=0, max_val=127;
  - max only at idx 9 (scores[9]=1, others -1) -> class_idx=9, max_val=1.
- Ties and negatives:
  - scores[2]=scores[6]=50, others 10 -> class_idx=2;
  - all -128 -> class_idx=0, max_val=-128.
- Snapshot and start-ignore: after start, change scores to all 127 and pulse start again during SCAN -> result still reflects the original vector; exactly one done; no restart.
- Hold and restart: after done, outputs and done stay stable for 20 idle cycles. A new start with a different vector -> done drops the next cycle, old class_idx/max_val persist during SCAN, then update to the new result.
- Reset mid-scan: assert rst at the 4th SCAN cycle -> next cycle busy=0, done=0, class_idx=0, max_val=0. A fresh start then completes normally with the correct result.
